regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning consecutive cycles B may be refused before B gets priority (legal range 1..7).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port clr  in  1  synchronous active-high reset.
REQ-005 SHALL have ports a_valid in 1, a_wn in 5, a_d in 32, a_ready out 1: requester A (ALU writeback).
REQ-006 SHALL have ports b_valid in 1, b_wn in 5, b_d in 32, b_ready out 1: requester B (load/IO writeback).
REQ-007 SHALL have ports wn out 5, d out 32, we out 1: registered regfile write port.
REQ-008 SHALL have ports rq in 5, rq_hit out 1, rq_data out 32: bypass query against the staged write.

Function
REQ-009 SHALL treat a transfer as valid&ready high on the same posedge; ready SHALL be combinational from valid inputs, b_wait and clr.
REQ-010 SHALL grant at most one requester per cycle; the write port never stalls.
REQ-011 SHALL, with only one valid, grant that requester.
REQ-012 SHALL, with both valid, be in state PRI_A (b_wait < STARVE_LIMIT, grant A) or PRI_B (b_wait == STARVE_LIMIT, grant B).
REQ-013 SHALL hold b_wait, 3-bit counter: +1 when b_valid&!b_ready, saturating at STARVE_LIMIT; 0 when b_valid low or B granted.
REQ-014 SHALL drive a_ready=b_ready=0 while clr is high.
REQ-015 SHALL, on a grant in cycle N, drive in cycle N+1: wn=granted wn, d=granted d, we=1.
REQ-016 SHALL, on a grant with wn==0, accept it (ready=1) but drive we=0, wn=0, d=0 in N+1.
REQ-017 SHALL, in a cycle after no grant, drive we=0, wn=0, d=0.
REQ-018 SHALL, with A and B targeting the same wn simultaneously, serialize them in grant order; the later grant's data SHALL be the final register value.
REQ-019 SHALL drive rq_hit=1 iff we==1 and rq==wn and rq!=0; rq_data=d when rq_hit, else 0; purely combinational.
REQ-020 SHALL leave a requester's ready low while it is refused; the requester holds wn/d stable until accepted (checked by bench, not by block).

Reset
REQ-021 SHALL, on posedge with clr=1, set we=0, wn=0, d=0, b_wait=0, discarding any in-flight grant.
REQ-022 SHALL output a_ready=b_ready=0, rq_hit=0, rq_data=0 in the first cycle after reset and until clr deasserts and a valid request appears.
REQ-023 SHALL resume normal arbitration on the first posedge with clr=0.

Verification
REQ-024 A-only: a_valid=1, a_wn=5, a_d=0xDEADBEEF in cycle 1 -> a_ready=1 cycle 1; cycle 2 we=1, wn=5, d=0xDEADBEEF; rq=5 gives rq_hit=1, rq_data=0xDEADBEEF; rq=6 gives rq_hit=0.
REQ-025 Contention: A and B continuously valid (a_wn=1, b_wn=2), STARVE_LIMIT=3 -> grant sequence A,A,A,B,A,A,A,B; we=1 every cycle after the first; b_wait peaks at 3.
REQ-026 r0 write: a_valid=1, a_wn=0, a_d=0x1 -> a_ready=1; next cycle we=0, wn=0, d=0; rq=0 gives rq_hit=0.
REQ-027 Reset mid-operation: A and B valid, b_wait=2, clr=1 for one cycle -> readies 0 during clr; next cycle we=0, b_wait=0; after clr low, A granted first, B waits 3 cycles again.
REQ-028 Wait abandon: B refused 2 cycles (b_wait=2), b_valid drops 1 cycle, returns -> b_wait restarts at 0; B granted only on 4th contended cycle.
REQ-029 Same target: A (wn=7, d=0x11) and B (wn=7, d=0x22) both valid, b_wait=3 -> B written first, A next cycle; final r7=0x11.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file.
// Two writeback sources compete for a single regfile write port. A (ALU) wins
// contention by default. B (load/IO) wins once it has been refused
// STARVE_LIMIT consecutive cycles. The granted write is staged one cycle and
// then presented on the write port. A combinational bypass query lets readers
// see the staged write before it lands in the register file.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        a_valid,
  input  logic [4:0]  a_wn,
  input  logic [31:0] a_d,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_wn,
  input  logic [31:0] b_d,
  output logic        b_ready,
  output logic [4:0]  wn,
  output logic [31:0] d,
  output logic        we,
  input  logic [4:0]  rq,
  output logic        rq_hit,
  output logic [31:0] rq_data
);

  localparam int WN_W   = 5;
  localparam int DATA_W = 32;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic {
    PRI_A,
    PRI_B
  } pri_t;

  pri_t              state_p0, state_nx;
  logic [2:0]        b_wait_p0, b_wait_nx;
  logic              a_gnt, b_gnt;

  logic [WN_W-1:0]   sel_wn;
  logic [DATA_W-1:0] sel_d;
  logic              sel_we;

  logic [WN_W-1:0]   wn_p1;
  logic [DATA_W-1:0] d_p1;
  logic              vld_p1;

  // Starvation counter increment that stops at the priority threshold.
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    if (v >= LIMIT) return LIMIT;
    return v + 3'd1;
  endfunction

  // Arbitration state register: priority state and B's refusal count.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_p0  <= PRI_A;
      b_wait_p0 <= 3'd0;
    end else begin
      state_p0  <= state_nx;
      b_wait_p0 <= b_wait_nx;
    end
  end

  // Grant decision and next priority state; readies are the grants themselves.
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    b_wait_nx = 3'd0;
    if (!clr) begin
      if (a_valid && b_valid) begin
        if (state_p0 == PRI_B) b_gnt = 1'b1;
        else                   a_gnt = 1'b1;
      end else if (a_valid) begin
        a_gnt = 1'b1;
      end else if (b_valid) begin
        b_gnt = 1'b1;
      end
      // A refused B keeps counting; dropping valid or being served restarts it.
      if (b_valid && !b_gnt) b_wait_nx = sat_inc(b_wait_p0);
      else                   b_wait_nx = 3'd0;
    end
    state_nx = (b_wait_nx == LIMIT) ? PRI_B : PRI_A;
  end

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;

  // Select the granted payload; writes to r0 are accepted but suppressed.
  always_comb begin
    sel_wn = a_wn;
    sel_d  = a_d;
    if (b_gnt) begin
      sel_wn = b_wn;
      sel_d  = b_d;
    end
    sel_we = (a_gnt || b_gnt) && (sel_wn != '0);
  end

  // Stage p1: registered write port, zeroed when nothing is written.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p1 <= 1'b0;
      wn_p1  <= '0;
      d_p1   <= '0;
    end else begin
      vld_p1 <= sel_we;
      wn_p1  <= sel_we ? sel_wn : '0;
      d_p1   <= sel_we ? sel_d  : '0;
    end
  end

  assign we = vld_p1;
  assign wn = wn_p1;
  assign d  = d_p1;

  // Bypass query against the staged write; r0 never hits.
  always_comb begin
    rq_hit  = vld_p1 && (rq == wn_p1) && (rq != '0);
    rq_data = rq_hit ? d_p1 : '0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_wn = '0;
  logic [31:0] a_d = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_wn = '0;
  logic [31:0] b_d = '0;
  logic        b_ready;
  logic [4:0]  wn;
  logic [31:0] d;
  logic        we;
  logic [4:0]  rq = '0;
  logic        rq_hit;
  logic [31:0] rq_data;

  int errs   = 0;
  int checks = 0;

  logic [31:0] shadow [32];

  regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .clr(clr),
    .a_valid(a_valid), .a_wn(a_wn), .a_d(a_d), .a_ready(a_ready),
    .b_valid(b_valid), .b_wn(b_wn), .b_d(b_d), .b_ready(b_ready),
    .wn(wn), .d(d), .we(we),
    .rq(rq), .rq_hit(rq_hit), .rq_data(rq_data)
  );

  always #5 clk = ~clk;

  // Mirror of the register file built from the write port.
  always @(posedge clk) begin
    if (we) shadow[wn] <= d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, check readies for this cycle and
  // the write port as left by the previous cycle's grant.
  task automatic cyc(input string tag, input logic r,
                     input logic av, input logic [4:0] awn, input logic [31:0] ad,
                     input logic bv, input logic [4:0] bwn, input logic [31:0] bd,
                     input logic ear, input logic ebr,
                     input logic ewe, input logic [4:0] ewn, input logic [31:0] ed);
    @(negedge clk);
    clr = r;
    a_valid = av; a_wn = awn; a_d = ad;
    b_valid = bv; b_wn = bwn; b_d = bd;
    #1;
    check({tag, ".a_ready"}, {31'd0, a_ready}, {31'd0, ear});
    check({tag, ".b_ready"}, {31'd0, b_ready}, {31'd0, ebr});
    check({tag, ".we"}, {31'd0, we}, {31'd0, ewe});
    check({tag, ".wn"}, {27'd0, wn}, {27'd0, ewn});
    check({tag, ".d"}, d, ed);
  endtask

  task automatic qchk(input string tag, input logic [4:0] q, input logic ehit, input logic [31:0] ed);
    rq = q;
    #1;
    check({tag, ".rq_hit"}, {31'd0, rq_hit}, {31'd0, ehit});
    check({tag, ".rq_data"}, rq_data, ed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour
    cyc("rst0", 1, 0,0,0, 0,0,0, 0,0, 0,0,0);
    cyc("rst1", 1, 1,3,32'h33, 1,4,32'h44, 0,0, 0,0,0);
    qchk("rst1", 3, 0, 0);
    cyc("rst2", 0, 0,0,0, 0,0,0, 0,0, 0,0,0);
    qchk("rst2", 4, 0, 0);

    // A only
    cyc("aonly", 0, 1,5,32'hDEADBEEF, 0,0,0, 1,0, 0,0,0);
    cyc("aonly_wr", 0, 0,0,0, 0,0,0, 0,0, 1,5,32'hDEADBEEF);
    qchk("aonly_q5", 5, 1, 32'hDEADBEEF);
    qchk("aonly_q6", 6, 0, 0);
    cyc("idle", 0, 0,0,0, 0,0,0, 0,0, 0,0,0);

    // r0 write accepted but suppressed
    cyc("r0", 0, 1,0,32'h1, 0,0,0, 1,0, 0,0,0);
    cyc("r0_wr", 0, 0,0,0, 0,0,0, 0,0, 0,0,0);
    qchk("r0_q0", 0, 0, 0);

    // B only
    cyc("bonly", 0, 0,0,0, 1,9,32'h99, 0,1, 0,0,0);
    cyc("bonly_wr", 0, 0,0,0, 0,0,0, 0,0, 1,9,32'h99);
    qchk("bonly_q9", 9, 1, 32'h99);

    // Continuous contention: A,A,A,B,A,A,A,B
    cyc("ct1", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 0,0,0);
    check("ct1.bwait", {29'd0, dut.b_wait_p0}, 0);
    cyc("ct2", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("ct3", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("ct4", 0, 1,1,32'hA1, 1,2,32'hB2, 0,1, 1,1,32'hA1);
    check("ct4.bwait", {29'd0, dut.b_wait_p0}, 3);
    cyc("ct5", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,2,32'hB2);
    qchk("ct5_q2", 2, 1, 32'hB2);
    qchk("ct5_q1", 1, 0, 0);
    cyc("ct6", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("ct7", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("ct8", 0, 1,1,32'hA1, 1,2,32'hB2, 0,1, 1,1,32'hA1);

    // Reset in the middle of contention with b_wait at 2
    cyc("mr1", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,2,32'hB2);
    cyc("mr2", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("mr_clr", 1, 1,1,32'hA1, 1,2,32'hB2, 0,0, 1,1,32'hA1);
    check("mr_clr.bwait", {29'd0, dut.b_wait_p0}, 2);
    cyc("mr3", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 0,0,0);
    check("mr3.bwait", {29'd0, dut.b_wait_p0}, 0);
    cyc("mr4", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("mr5", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("mr6", 0, 1,1,32'hA1, 1,2,32'hB2, 0,1, 1,1,32'hA1);
    cyc("mr7", 0, 0,0,0, 0,0,0, 0,0, 1,2,32'hB2);

    // B abandons its wait for one cycle and restarts the count
    cyc("wa1", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 0,0,0);
    cyc("wa2", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("wa_drop", 0, 1,1,32'hA1, 0,0,0, 1,0, 1,1,32'hA1);
    check("wa_drop.bwait", {29'd0, dut.b_wait_p0}, 2);
    cyc("wa3", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    check("wa3.bwait", {29'd0, dut.b_wait_p0}, 0);
    cyc("wa4", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("wa5", 0, 1,1,32'hA1, 1,2,32'hB2, 1,0, 1,1,32'hA1);
    cyc("wa6", 0, 1,1,32'hA1, 1,2,32'hB2, 0,1, 1,1,32'hA1);
    cyc("wa7", 0, 0,0,0, 0,0,0, 0,0, 1,2,32'hB2);

    // Same target register, B holds priority: B lands first, A last
    cyc("st1", 0, 1,1,32'hA1, 1,7,32'h22, 1,0, 0,0,0);
    cyc("st2", 0, 1,1,32'hA1, 1,7,32'h22, 1,0, 1,1,32'hA1);
    cyc("st3", 0, 1,1,32'hA1, 1,7,32'h22, 1,0, 1,1,32'hA1);
    cyc("st4", 0, 1,7,32'h11, 1,7,32'h22, 0,1, 1,1,32'hA1);
    cyc("st5", 0, 1,7,32'h11, 0,0,0, 1,0, 1,7,32'h22);
    qchk("st5_q7", 7, 1, 32'h22);
    cyc("st6", 0, 0,0,0, 0,0,0, 0,0, 1,7,32'h11);
    qchk("st6_q7", 7, 1, 32'h11);
    cyc("st7", 0, 0,0,0, 0,0,0, 0,0, 0,0,0);
    check("st.r7_final", shadow[7], 32'h11);
    check("st.r1_final", shadow[1], 32'hA1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
